// File: rtl/float_subtractor_e4m3_seq.sv
// float_subtractor_e4m3_seq: multi-cycle E4M3 y = a - b (truncating); flags port only with FP8_SUB_FLAGS_EN
module float_subtractor_e4m3_seq #(
    parameter int GUARD_BITS = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] y
`ifdef FP8_SUB_FLAGS_EN
    ,
    output logic [2:0] flags
`endif
);
    localparam int W = GUARD_BITS + 5;
    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;
    state_t state_q, state_d;
    logic [7:0] a_q, a_d, b_q, b_d, y_q, y_d;
    logic [W-1:0] big_q, big_d, sml_q, sml_d;
    logic [W:0] mag_q, mag_d, sum;
    logic [4:0] exp_q, exp_d;
    logic sbig_q, sbig_d, ssml_q, ssml_d, sign_q, sign_d;
    logic a_big, nan, zero, unf, ovf;
    logic [3:0] ea, eb, siga, sigb, dexp;
    logic [7:0] sh;
    logic [2*W-1:0] wide;
`ifdef FP8_SUB_FLAGS_EN
    logic [2:0] flags_q, flags_d;
`endif
    assign in_ready = state_q == IDLE && !rst;
    assign out_valid = state_q == DONE;
    assign y = y_q;
`ifdef FP8_SUB_FLAGS_EN
    assign flags = flags_q;
`endif
    always_comb begin
        ea = a_q[6:3];
        eb = b_q[6:3];
        siga = (ea == 4'd0) ? 4'd0 : {1'b1, a_q[2:0]};
        sigb = (eb == 4'd0) ? 4'd0 : {1'b1, b_q[2:0]};
        a_big = ea >= eb;
        dexp = a_big ? ea - eb : eb - ea;
        sh = (int'(dexp) > W) ? 8'(W) : {4'd0, dexp};
        wide = {(a_big ? sigb : siga), {(2*W-4){1'b0}}} >> sh;
        sum = (sbig_q == ssml_q) ? {1'b0, big_q} + {1'b0, sml_q} :
              (big_q >= sml_q) ? {1'b0, big_q - sml_q} : {1'b0, sml_q - big_q};
        zero = mag_q == '0;
        unf = !zero && !mag_q[W-1];
        ovf = !zero && !unf && (exp_q > 5'd15 || (exp_q == 5'd15 && mag_q[W-2:W-4] == 3'b111));
        nan = a_q[6:0] == 7'h7F || b_q[6:0] == 7'h7F;
        state_d = state_q;
        a_d = a_q;
        b_d = b_q;
        y_d = y_q;
        big_d = big_q;
        sml_d = sml_q;
        mag_d = mag_q;
        exp_d = exp_q;
        sbig_d = sbig_q;
        ssml_d = ssml_q;
        sign_d = sign_q;
`ifdef FP8_SUB_FLAGS_EN
        flags_d = flags_q;
`endif
        case (state_q)
            IDLE: if (in_valid) begin
                a_d = a;
                b_d = b;
                state_d = ALIGN;
            end
            ALIGN: begin
                big_d = {(a_big ? siga : sigb), {(W-4){1'b0}}};
                sml_d = {wide[2*W-1:W+1], wide[W] | (|wide[W-1:0])};
                sbig_d = a_big ? a_q[7] : ~b_q[7];
                ssml_d = a_big ? ~b_q[7] : a_q[7];
                exp_d = {1'b0, a_big ? ea : eb};
                state_d = ADD;
            end
            ADD: begin
                sign_d = (sbig_q == ssml_q || big_q >= sml_q) ? sbig_q : ssml_q;
                mag_d = sum[W] ? {1'b0, sum[W:2], sum[1] | sum[0]} : sum;
                exp_d = exp_q + 5'(sum[W]);
                state_d = NORM;
            end
            NORM: if (!zero && !mag_q[W-1] && exp_q > 5'd1) begin
                mag_d = mag_q << 1;
                exp_d = exp_q - 5'd1;
            end else begin
                y_d = nan ? 8'h7F : (zero || unf) ? 8'h00 : ovf ? {sign_q, 7'h7E} :
                      {sign_q, exp_q[3:0], mag_q[W-2:W-4]};
`ifdef FP8_SUB_FLAGS_EN
                flags_d = (nan || zero) ? 3'b000 : {ovf, unf, unf | ovf | (|mag_q[W-5:0])};
`endif
                state_d = DONE;
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q <= '0;
            b_q <= '0;
            y_q <= '0;
            big_q <= '0;
            sml_q <= '0;
            mag_q <= '0;
            exp_q <= '0;
            sbig_q <= 1'b0;
            ssml_q <= 1'b0;
            sign_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q <= a_d;
            b_q <= b_d;
            y_q <= y_d;
            big_q <= big_d;
            sml_q <= sml_d;
            mag_q <= mag_d;
            exp_q <= exp_d;
            sbig_q <= sbig_d;
            ssml_q <= ssml_d;
            sign_q <= sign_d;
        end
    end
`ifdef FP8_SUB_FLAGS_EN
    always_ff @(posedge clk) begin
        if (rst) flags_q <= 3'b000;
        else flags_q <= flags_d;
    end
`endif
endmodule

// File: tb/tb_float_subtractor_e4m3_seq.sv
// tb_float_subtractor_e4m3_seq: value-level model of E4M3 subtraction plus directed literal vectors
module tb_float_subtractor_e4m3_seq;
    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
    logic [7:0] a = 8'h00, b = 8'h00;
    logic in_ready, out_valid;
    logic [7:0] y;
`ifdef FP8_SUB_FLAGS_EN
    logic [2:0] flags;
`endif
    int n_chk = 0, n_fail = 0;
    logic pending = 1'b0;
    logic [10:0] exp_r = '0;
    logic [7:0] cap_a = '0, cap_b = '0, gy;
    int lat;

    float_subtractor_e4m3_seq dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .y(y)
`ifdef FP8_SUB_FLAGS_EN
        , .flags(flags)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, req, req, $time);
        end
    endtask

    // value in units of 2^-9, so every finite E4M3 number is an integer
    function automatic int val(input logic [7:0] x);
        int e, v;
        e = int'(x[6:3]);
        v = (e == 0) ? 0 : (8 + int'(x[2:0])) << (e - 1);
        return x[7] ? -v : v;
    endfunction

    // {overflow, underflow, inexact, y}
    function automatic logic [10:0] model(input logic [7:0] x, input logic [7:0] z);
        int d, m, p, mant, fld;
        logic s, ex;
        if (x[6:0] == 7'h7F || z[6:0] == 7'h7F) return {3'b000, 8'h7F};
        d = val(x) - val(z);
        s = d < 0;
        m = s ? -d : d;
        if (m == 0) return 11'd0;
        if (m < 8) return {3'b011, 8'h00};
        p = 3;
        while ((m >> (p + 1)) != 0) p++;
        mant = (m >> (p - 3)) & 7;
        fld = p - 2;
        ex = (m & ((1 << (p - 3)) - 1)) != 0;
        if (fld > 15 || (fld == 15 && mant == 7)) return {3'b101, s, 7'h7E};
        return {2'b00, ex, s, 4'(fld), 3'(mant)};
    endfunction

    always @(negedge clk) begin
        if (pending && out_valid) begin
            chk("y", int'(y), int'(exp_r[7:0]));
            chk("busy_in_ready", int'(in_ready), 0);
            if (exp_r[7:0] != 8'h7F && exp_r[10:8] == 3'b000)
                chk("exact_value", val(y), val(cap_a) - val(cap_b));
`ifdef FP8_SUB_FLAGS_EN
            chk("flags", int'(flags), int'(exp_r[10:8]));
`endif
        end
    end

    task automatic op(input logic [7:0] ta, input logic [7:0] tb, input int hold,
                      output logic [7:0] oy, output int olat);
        int t;
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) chk("in_ready_timeout", 0, 1);
        a = ta;
        b = tb;
        cap_a = ta;
        cap_b = tb;
        exp_r = model(ta, tb);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        pending = 1'b1;
        olat = 0;
        while (!out_valid && olat < 40) begin
            @(posedge clk);
            #1;
            olat++;
        end
        if (!out_valid) chk("out_valid_timeout", 0, 1);
        oy = y;
        repeat (hold) begin
            in_valid = 1'($urandom_range(0, 1));
            a = 8'($urandom);
            b = 8'($urandom);
            @(posedge clk);
            #1;
            chk("held_out_valid", int'(out_valid), 1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        pending = 1'b0;
        chk("released", int'(out_valid), 0);
    endtask

    logic [7:0] lit_a [7] = '{8'h48, 8'h40, 8'h40, 8'h29, 8'h50, 8'hFE, 8'h7F};
    logic [7:0] lit_b [7] = '{8'h40, 8'h40, 8'hC0, 8'h10, 8'h10, 8'h7E, 8'h40};
    logic [7:0] lit_y [7] = '{8'h40, 8'h00, 8'h48, 8'h28, 8'h4F, 8'hFE, 8'h7F};
    logic [2:0] lit_f [7] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 3'b101, 3'b000};
    logic [7:0] dir_a [11] = '{8'h09, 8'h78, 8'h00, 8'h80, 8'hFF, 8'h7E, 8'h7E, 8'h7E, 8'h3F, 8'h08, 8'h41};
    logic [7:0] dir_b [11] = '{8'h08, 8'h01, 8'h40, 8'h00, 8'h00, 8'h08, 8'hC0, 8'hF0, 8'h38, 8'h10, 8'h40};

    initial begin
        int quiet;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_y", int'(y), 0);
        rst = 1'b0;
        #1;
        chk("idle_in_ready", int'(in_ready), 1);
        for (int i = 0; i < 7; i++) begin
            op(lit_a[i], lit_b[i], 0, gy, lat);
            chk("lit_y", int'(gy), int'(lit_y[i]));
`ifdef FP8_SUB_FLAGS_EN
            chk("lit_flags", int'(flags), int'(lit_f[i]));
`endif
            if (i == 0) chk("latency_k1", lat, 4);
        end
        op(8'h29, 8'h10, 5, gy, lat);
        chk("hold_y", int'(gy), 8'h28);
        for (int i = 0; i < 11; i++) op(dir_a[i], dir_b[i], 0, gy, lat);
        chk("latency_k3", lat, 6);
        chk("lit_k3_y", int'(gy), 8'h28);
        repeat (300) op(8'($urandom), 8'($urandom), 0, gy, lat);
        op(8'h48, 8'h40, 0, gy, lat);
        @(negedge clk);
        a = 8'h48;
        b = 8'h40;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_out_valid", int'(out_valid), 0);
        chk("mid_rst_y", int'(y), 0);
        chk("mid_rst_in_ready", int'(in_ready), 0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", int'(in_ready), 1);
        quiet = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            quiet += int'(out_valid);
        end
        chk("abandoned_job_silent", quiet, 0);
        op(8'h48, 8'h40, 0, gy, lat);
        chk("post_rst_y", int'(gy), 8'h40);
        chk("post_rst_latency", lat, 4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
